// File: rtl/prio_encoder_stream.sv
// Streaming priority encoder: accepts a request vector and emits one beat per
// set bit (or a single "none" beat for an all-zero vector), in LSB- or MSB-first order.
//
//   state | meaning
//   IDLE  | ready for a new vector, no beat on the output
//   EMIT  | walking the latched mask, one beat per handshake
module prio_encoder_stream #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic             out_onehot,
  output logic [IDX_W:0]   out_seq
);

  localparam int SEQ_W = IDX_W + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mask;
  logic             mask_multi;
  logic             in_nz;
  logic             in_multi;

  always_comb begin
    out_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (mask[i]) out_idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (mask[i]) out_idx = IDX_W'(i);
    end
  end

  // x & (x-1) is nonzero exactly when x has two or more bits set
  assign mask_multi = |(mask & (mask - WIDTH'(1)));
  assign in_nz      = |in_data;
  assign in_multi   = |(in_data & (in_data - WIDTH'(1)));

  // Gated by rst so both handshake signals are low during the reset cycle
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == EMIT) && !rst;
  assign out_last  = (state == EMIT) && !mask_multi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      out_seq    <= '0;
      out_none   <= 1'b0;
      out_onehot <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mask       <= in_data;
            out_none   <= ~in_nz;
            out_onehot <= in_nz & ~in_multi;
            out_seq    <= '0;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            mask    <= mask & ~(WIDTH'(1) << out_idx);
            out_seq <= out_seq + SEQ_W'(1);
            if (out_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Bench for prio_encoder_stream: LSB-first and MSB-first instances share the
// stimulus and are checked against a bit-list model of the expected beats.
module tb_prio_encoder_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        ir0, ov0, last0, none0, oh0;
  logic [4:0]  idx0;
  logic [5:0]  seq0;
  logic        ir1, ov1, last1, none1, oh1;
  logic [4:0]  idx1;
  logic [5:0]  seq1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prio_encoder_stream #(.WIDTH(32), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_idx(idx0), .out_last(last0),
    .out_none(none0), .out_onehot(oh0), .out_seq(seq0)
  );

  prio_encoder_stream #(.WIDTH(32), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_idx(idx1), .out_last(last1),
    .out_none(none1), .out_onehot(oh1), .out_seq(seq1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] d);
    chk("accept_ready0", 32'(ir0), 1);
    chk("accept_ready1", 32'(ir1), 1);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Walks every expected beat of d; with stall set, out_ready toggles randomly
  // so stalled cycles re-check the same beat (fields must hold).
  task automatic drain(input logic [31:0] d, input bit stall);
    int q0[$];
    int q1[$];
    int pc, n, beat, cyc;
    pc = 0;
    for (int i = 0; i < 32; i++) if (d[i]) begin q0.push_back(i); pc++; end
    for (int i = 31; i >= 0; i--) if (d[i]) q1.push_back(i);
    if (pc == 0) begin q0.push_back(0); q1.push_back(0); end
    n = q0.size();
    beat = 0;
    cyc = 0;
    while (beat < n && cyc < 400) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beat == n - 1) in_valid = 1'b0;
      else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      chk("valid0", 32'(ov0), 1);
      chk("valid1", 32'(ov1), 1);
      chk("busy_ready0", 32'(ir0), 0);
      chk("idx0", 32'(idx0), 32'(q0[beat]));
      chk("idx1", 32'(idx1), 32'(q1[beat]));
      chk("seq0", 32'(seq0), 32'(beat));
      chk("seq1", 32'(seq1), 32'(beat));
      chk("last0", 32'(last0), 32'(beat == n - 1));
      chk("last1", 32'(last1), 32'(beat == n - 1));
      chk("none0", 32'(none0), 32'(pc == 0));
      chk("none1", 32'(none1), 32'(pc == 0));
      chk("onehot0", 32'(oh0), 32'(pc == 1));
      chk("onehot1", 32'(oh1), 32'(pc == 1));
      step();
      if (out_ready) beat++;
      cyc++;
    end
    if (beat < n) chk("beat_timeout", 32'(beat), 32'(n));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("done_valid0", 32'(ov0), 0);
    chk("done_valid1", 32'(ov1), 0);
    chk("done_ready0", 32'(ir0), 1);
    chk("done_ready1", 32'(ir1), 1);
  endtask

  typedef struct {
    logic [31:0] data;
    int          idx_lsb;
    int          idx_msb;
    bit          last;
    bit          onehot;
    bit          none;
    bit          stall;
  } vec_t;

  initial begin
    vec_t tbl[7];
    logic [31:0] d;
    tbl[0] = '{32'h0000_0400, 10, 10, 1, 1, 0, 0};
    tbl[1] = '{32'h8000_0011,  0, 31, 0, 0, 0, 0};
    tbl[2] = '{32'h0000_0000,  0,  0, 1, 0, 1, 0};
    tbl[3] = '{32'h0000_0001,  0,  0, 1, 1, 0, 0};
    tbl[4] = '{32'h8000_0000, 31, 31, 1, 1, 0, 1};
    tbl[5] = '{32'hFFFF_FFFF,  0, 31, 0, 0, 0, 1};
    tbl[6] = '{32'h0000_0F00,  8, 11, 0, 0, 0, 1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(ir0), 0);
    chk("rst_valid", 32'(ov0), 0);
    chk("rst_idx", 32'(idx0), 0);
    chk("rst_last", 32'(last0), 0);
    chk("rst_none", 32'(none0), 0);
    chk("rst_onehot", 32'(oh0), 0);
    chk("rst_seq", 32'(seq0), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ir0), 1);

    for (int t = 0; t < 7; t++) begin
      accept(tbl[t].data);
      chk("tbl_idx_lsb", 32'(idx0), 32'(tbl[t].idx_lsb));
      chk("tbl_idx_msb", 32'(idx1), 32'(tbl[t].idx_msb));
      chk("tbl_last", 32'(last0), 32'(tbl[t].last));
      chk("tbl_onehot", 32'(oh0), 32'(tbl[t].onehot));
      chk("tbl_none", 32'(none0), 32'(tbl[t].none));
      chk("tbl_seq", 32'(seq0), 0);
      drain(tbl[t].data, tbl[t].stall);
      step();
    end

    // Reset mid-stream abandons the vector
    accept(32'h0000_00F0);
    out_ready = 1'b1;
    chk("mid_idx_b0", 32'(idx0), 4);
    step();
    chk("mid_idx_b1", 32'(idx0), 5);
    chk("mid_seq_b1", 32'(seq0), 1);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ov0), 0);
    chk("mid_rst_ready", 32'(ir0), 0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_after_ready", 32'(ir0), 1);
    chk("mid_after_seq", 32'(seq0), 0);
    chk("mid_after_idx", 32'(idx0), 0);
    chk("mid_after_last", 32'(last0), 0);
    for (int c = 0; c < 3; c++) begin
      chk("mid_no_beat", 32'(ov0) | 32'(ov1), 0);
      step();
    end
    out_ready = 1'b0;
    accept(32'h0000_0001);
    chk("mid_new_idx", 32'(idx0), 0);
    chk("mid_new_seq", 32'(seq0), 0);
    drain(32'h0000_0001, 1'b0);
    step();

    // Reset wins over a simultaneous in_valid
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h0000_00FF;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rstprio_valid", 32'(ov0), 0);
    chk("rstprio_ready", 32'(ir0), 1);

    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = $urandom & $urandom & $urandom;
        2: d = 32'h1 << $urandom_range(0, 31);
        default: d = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom & $urandom);
      endcase
      accept(d);
      drain(d, 1'($urandom_range(0, 1)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
